// File: rtl/alu.sv
// W-bit registered ALU: AND/OR/ADD/SUB/SLT(unsigned)/NOR with carry and zero flags, 1-cycle latency.
// Optional signed-overflow output enabled by defining ALU_OVF_EN.
module alu #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   alu_ctrl,
  output logic [W-1:0] alu_o,
  output logic         cout,
  output logic         zero
`ifdef ALU_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  logic [W:0]   add_sum;
  logic [W:0]   sub_sum;
  logic         lt;
  logic [W-1:0] alu_d, alu_q;
  logic         cout_d, cout_q;
  logic         zero_d, zero_q;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  // SLT reuses the subtractor: no carry out means a borrow, i.e. a < b unsigned
  assign lt      = ~sub_sum[W];

  always_comb begin
    alu_d  = '0;
    cout_d = 1'b0;
    case (alu_ctrl)
      OP_AND: alu_d = a & b;
      OP_OR:  alu_d = a | b;
      OP_ADD: {cout_d, alu_d} = add_sum;
      OP_SUB: {cout_d, alu_d} = sub_sum;
      OP_SLT: alu_d = {{(W-1){1'b0}}, lt};
      OP_NOR: alu_d = ~(a | b);
      default: alu_d = '0;
    endcase
    zero_d = (alu_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q  <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      alu_q  <= alu_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
    end
  end

  assign alu_o = alu_q;
  assign cout  = cout_q;
  assign zero  = zero_q;

`ifdef ALU_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    case (alu_ctrl)
      OP_ADD: ovf_d = (a[W-1] == b[W-1]) && (add_sum[W-1] != a[W-1]);
      OP_SUB: ovf_d = (a[W-1] != b[W-1]) && (sub_sum[W-1] != a[W-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (W=8): directed vectors plus a randomized sweep against a small model.
module tb_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_o;
  logic         cout, zero;
`ifdef ALU_OVF_EN
  logic         ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  alu #(.W(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .alu_ctrl(alu_ctrl),
    .alu_o(alu_o), .cout(cout), .zero(zero)
`ifdef ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic r, input logic [7:0] va, input logic [7:0] vb, input logic [3:0] op);
    rst = r; a = va; b = vb; alu_ctrl = op;
    @(posedge clk);
    #1;
  endtask

  // reference model built on plain integer arithmetic
  task automatic model(input int va, input int vb, input int op,
                       output int res, output int c, output int v);
    int sa, sb, s;
    sa = (va >= 128) ? va - 256 : va;
    sb = (vb >= 128) ? vb - 256 : vb;
    res = 0; c = 0; v = 0;
    case (op)
      0:  res = va & vb;
      1:  res = va | vb;
      2:  begin res = (va + vb) % 256; c = (va + vb > 255); s = sa + sb; v = (s > 127 || s < -128); end
      6:  begin res = (va - vb + 256) % 256; c = (va >= vb); s = sa - sb; v = (s > 127 || s < -128); end
      7:  res = (va < vb) ? 1 : 0;
      12: res = 255 - (va | vb);
      default: res = 0;
    endcase
  endtask

  initial begin
    int codes[6] = '{0, 1, 2, 6, 7, 12};
    int er, ec, ev;
    logic [7:0] ra, rb;
    logic [3:0] rop;

    // reset holds outputs regardless of inputs
    drive(1'b1, 8'hFF, 8'h01, 4'd2);
    chk("rst_alu", alu_o, 0); chk("rst_cout", cout, 0); chk("rst_zero", zero, 1);
`ifdef ALU_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    drive(1'b0, 8'hFF, 8'h01, 4'd2);
    chk("first_alu", alu_o, 8'h00); chk("first_cout", cout, 1); chk("first_zero", zero, 1);

    drive(1'b0, 8'hCC, 8'hAA, 4'd0);
    chk("and_alu", alu_o, 8'h88); chk("and_zero", zero, 0); chk("and_cout", cout, 0);
    drive(1'b0, 8'hCC, 8'hAA, 4'd1);
    chk("or_alu", alu_o, 8'hEE);
    drive(1'b0, 8'hF0, 8'h0F, 4'd12);
    chk("nor0_alu", alu_o, 8'h00); chk("nor0_zero", zero, 1);
    drive(1'b0, 8'h00, 8'h00, 4'd12);
    chk("norff_alu", alu_o, 8'hFF); chk("norff_zero", zero, 0);

    drive(1'b0, 8'd200, 8'd100, 4'd2);
    chk("add_alu", alu_o, 44); chk("add_cout", cout, 1);
    drive(1'b0, 8'd5, 8'd7, 4'd6);
    chk("sub_alu", alu_o, 254); chk("sub_cout", cout, 0); chk("sub_zero", zero, 0);
    drive(1'b0, 8'd7, 8'd7, 4'd6);
    chk("subeq_alu", alu_o, 0); chk("subeq_cout", cout, 1); chk("subeq_zero", zero, 1);
`ifdef ALU_OVF_EN
    drive(1'b0, 8'h7F, 8'h01, 4'd2);
    chk("add_ovf", ovf, 1); chk("add_ovf_alu", alu_o, 8'h80);
`endif

    drive(1'b0, 8'd3, 8'd9, 4'd7);
    chk("slt_t_alu", alu_o, 1); chk("slt_t_zero", zero, 0);
    drive(1'b0, 8'd9, 8'd3, 4'd7);
    chk("slt_f_alu", alu_o, 0); chk("slt_f_zero", zero, 1);
    drive(1'b0, 8'h80, 8'h7F, 4'd7);
    chk("slt_uns_alu", alu_o, 0);

    drive(1'b0, 8'h55, 8'h55, 4'd5);
    chk("und5_alu", alu_o, 0); chk("und5_cout", cout, 0); chk("und5_zero", zero, 1);
    drive(1'b0, 8'hFF, 8'hFF, 4'd2);
    chk("pre15_cout", cout, 1);
    drive(1'b0, 8'h55, 8'h55, 4'd15);
    chk("und15_alu", alu_o, 0); chk("und15_cout", cout, 0); chk("und15_zero", zero, 1);

    // random sweep with a one-cycle reset pulse midway
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 4'(codes[$urandom_range(0, 5)]);
      if (i == 500) begin
        drive(1'b1, ra, rb, rop);
        er = 0; ec = 0; ev = 0;
        chk("mid_rst_zero", zero, 1);
      end else begin
        drive(1'b0, ra, rb, rop);
        model(int'(ra), int'(rb), int'(rop), er, ec, ev);
        chk("rnd_zero", zero, (er == 0) ? 1 : 0);
      end
      chk("rnd_alu", alu_o, er);
      chk("rnd_cout", cout, ec);
`ifdef ALU_OVF_EN
      chk("rnd_ovf", ovf, ev);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
